// File: rtl/ctrl_decode.sv
// ctrl_decode: multi-cycle fetch/decode/execute/writeback controller with PC sequencing and branch resolution
module ctrl_decode #(
  parameter int PC_STEP = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic        INSTR_VALID,
  input  logic        ZERO,
  output logic [31:0] PC,
  output logic [2:0]  INADDRESS,
  output logic [2:0]  OUT1ADDRESS,
  output logic [2:0]  OUT2ADDRESS,
  output logic        WRITE,
  output logic [7:0]  IMMEDIATE,
  output logic [2:0]  ALUOP,
  output logic        IMM_SEL,
  output logic        NEG_SEL,
  output logic        ILLEGAL
);
  typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, WRITEBACK} state_t;
  state_t state, next;
  logic [31:0] ir, pc_next, offset;
  logic [7:0] op, ir_op;
  logic [2:0] dec_aluop;
  logic latch, writes, take;
  assign op = INSTRUCTION[31:24];
  assign ir_op = ir[31:24];
  assign latch = state == FETCH && INSTR_VALID;
  assign dec_aluop = (op == 8'd2 || op == 8'd3 || op == 8'd7) ? 3'b001 :
                     op == 8'd4 ? 3'b010 :
                     op == 8'd5 ? 3'b011 : 3'b000;
  assign writes = ir_op < 8'd6;
  assign take = ir_op == 8'd6 || (ir_op == 8'd7 && ZERO);
  // word offset, sign-extended and scaled to bytes
  assign offset = {{22{ir[23]}}, ir[23:16], 2'b00};
  assign pc_next = PC + 32'(PC_STEP) + (take ? offset : 32'd0);
  always_comb begin
    next = state;
    next = state == FETCH   ? (INSTR_VALID ? DECODE : FETCH) :
           state == DECODE  ? EXECUTE :
           state == EXECUTE ? (writes ? WRITEBACK : FETCH) : FETCH;
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= FETCH;
      ir      <= '0;
      PC      <= '0;
      ALUOP   <= '0;
      IMM_SEL <= 1'b0;
      NEG_SEL <= 1'b0;
      ILLEGAL <= 1'b0;
    end else begin
      state <= next;
      if (latch) begin
        ir      <= INSTRUCTION;
        ALUOP   <= dec_aluop;
        IMM_SEL <= op == 8'd0;
        NEG_SEL <= op == 8'd3 || op == 8'd7;
        ILLEGAL <= ILLEGAL || op > 8'd7;
      end
      if (state == EXECUTE) PC <= pc_next;
    end
  end
  assign INADDRESS   = ir[18:16];
  assign OUT1ADDRESS = ir[10:8];
  assign OUT2ADDRESS = ir[2:0];
  assign IMMEDIATE   = ir[7:0];
  assign WRITE       = state == WRITEBACK;
endmodule

// File: tb/tb_ctrl_decode.sv
// tb_ctrl_decode: directed-vector bench for ctrl_decode
module tb_ctrl_decode;
  logic        CLK = 0, RESET = 0, INSTR_VALID = 0, ZERO = 0;
  logic [31:0] INSTRUCTION = '0;
  logic [31:0] PC;
  logic [2:0]  INADDRESS, OUT1ADDRESS, OUT2ADDRESS, ALUOP;
  logic [7:0]  IMMEDIATE;
  logic        WRITE, IMM_SEL, NEG_SEL, ILLEGAL;
  int checks = 0, failures = 0;
  ctrl_decode #(.PC_STEP(4)) dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID),
    .ZERO(ZERO), .PC(PC), .INADDRESS(INADDRESS), .OUT1ADDRESS(OUT1ADDRESS),
    .OUT2ADDRESS(OUT2ADDRESS), .WRITE(WRITE), .IMMEDIATE(IMMEDIATE), .ALUOP(ALUOP),
    .IMM_SEL(IMM_SEL), .NEG_SEL(NEG_SEL), .ILLEGAL(ILLEGAL)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic edge1;
    @(posedge CLK); #1;
  endtask
  // issue one instruction; INSTRUCTION is scrambled after the fetch edge
  task automatic run(input logic [31:0] ins, input logic z, input bit w);
    int wcount = 0;
    INSTRUCTION = ins; INSTR_VALID = 1; ZERO = z;
    edge1;
    INSTR_VALID = 0; INSTRUCTION = ~ins;
    if (WRITE) wcount++;
    edge1;
    if (WRITE) wcount++;
    edge1;
    chk("write_on_3rd_edge", {31'd0, WRITE}, {31'd0, w});
    if (w) begin
      edge1;
      chk("write_drop_4th_edge", {31'd0, WRITE}, 32'd0);
    end
    chk("write_early", wcount, 0);
  endtask
  initial begin
    RESET = 1; #2;
    chk("rst_pc", PC, 0);
    chk("rst_write", {31'd0, WRITE}, 0);
    chk("rst_illegal", {31'd0, ILLEGAL}, 0);
    chk("rst_ctrl", {INADDRESS, OUT1ADDRESS, OUT2ADDRESS, IMMEDIATE, ALUOP, IMM_SEL, NEG_SEL}, 0);
    @(negedge CLK); RESET = 0;
    run(32'h0004002A, 0, 1);
    chk("loadi_inaddr", INADDRESS, 4);
    chk("loadi_imm", IMMEDIATE, 8'h2A);
    chk("loadi_immsel", {31'd0, IMM_SEL}, 1);
    chk("loadi_aluop", ALUOP, 0);
    chk("loadi_pc", PC, 4);
    run(32'h03010203, 0, 1);
    chk("sub_aluop", ALUOP, 1);
    chk("sub_neg", {31'd0, NEG_SEL}, 1);
    chk("sub_immsel", {31'd0, IMM_SEL}, 0);
    chk("sub_addrs", {INADDRESS, OUT1ADDRESS, OUT2ADDRESS}, {3'd1, 3'd2, 3'd3});
    chk("sub_pc", PC, 8);
    run(32'h01050600, 0, 1);
    chk("mov_aluop", ALUOP, 0);
    chk("mov_pc", PC, 32'h0C);
    run(32'h02070102, 0, 1);
    chk("add_aluop_neg", {ALUOP, NEG_SEL}, {3'b001, 1'b0});
    chk("add_pc", PC, 32'h10);
    run(32'h07FE0000, 1, 0);
    chk("beq_taken_pc", PC, 32'h0C);
    run(32'h04010203, 0, 1);
    chk("and_aluop", ALUOP, 2);
    chk("and_pc", PC, 32'h10);
    run(32'h07FE0000, 0, 0);
    chk("beq_not_taken_pc", PC, 32'h14);
    chk("beq_ctrl", {ALUOP, NEG_SEL}, {3'b001, 1'b1});
    run(32'h06F90000, 0, 0);
    chk("j_back_pc", PC, 32'hFFFFFFFC);
    run(32'h06010000, 0, 0);
    chk("j_wrap_pc", PC, 32'h4);
    INSTRUCTION = 32'h0F0F0F0F;
    repeat (3) edge1;
    chk("idle_pc", PC, 4);
    chk("idle_write", {31'd0, WRITE}, 0);
    chk("idle_inaddr", INADDRESS, 1);
    chk("idle_illegal", {31'd0, ILLEGAL}, 0);
    run(32'h09000000, 0, 0);
    chk("illegal_flag", {31'd0, ILLEGAL}, 1);
    chk("illegal_pc", PC, 8);
    run(32'h05020304, 0, 1);
    chk("or_aluop", ALUOP, 3);
    chk("illegal_sticky", {31'd0, ILLEGAL}, 1);
    chk("or_pc", PC, 32'h0C);
    INSTRUCTION = 32'h05020304; INSTR_VALID = 1;
    edge1;
    INSTR_VALID = 0;
    edge1; edge1;
    chk("wb_before_reset", {31'd0, WRITE}, 1);
    #2 RESET = 1; #1;
    chk("async_write", {31'd0, WRITE}, 0);
    chk("async_pc", PC, 0);
    chk("async_illegal", {31'd0, ILLEGAL}, 0);
    chk("async_aluop", ALUOP, 0);
    #1 RESET = 0;
    edge1; edge1;
    chk("post_reset_write", {31'd0, WRITE}, 0);
    chk("post_reset_pc", PC, 0);
    run(32'h00030011, 0, 1);
    chk("post_reset_inaddr", INADDRESS, 3);
    chk("post_reset_pc2", PC, 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
